// File: rtl/conv_frame_sequencer.sv
// Frame input stage for the rate-1/2 convolutional encoder: captures one frame
// of info bits, then replays it as seed load, data bits and an optional zero tail.
module conv_frame_sequencer #(
  parameter int K       = 4,
  parameter int M       = K - 1,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_tailbite,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             enc_seed_load,
  output logic [M-1:0]     enc_seed_value,
  output logic             enc_in_valid,
  output logic             enc_in_bit,
  output logic             frame_sof,
  output logic             frame_eof,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  localparam int TCNT_W = (M > 1) ? $clog2(M + 1) : 1;

  localparam logic [LEN_W-1:0]  MAX_LEN_CFG = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  M_CFG       = LEN_W'(M);
  localparam logic [TCNT_W-1:0] M_TAIL      = TCNT_W'(M);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [TCNT_W-1:0] TCNT_ONE    = TCNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SEED,
    DATA,
    TAIL,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   len_reg;
  logic               tailbite_reg;
  logic [CNT_W-1:0]   wcnt;
  logic [CNT_W-1:0]   rcnt;
  logic [TCNT_W-1:0]  tcnt;
  logic [M-1:0]       lastbits;
  logic [M-1:0]       lastbits_next;
  logic               frame_mem [MAX_LEN];

  logic               wr_en;
  logic               cfg_legal;
  logic [CNT_W-1:0]   wcnt_inc;
  logic [CNT_W-1:0]   rcnt_inc;
  logic [TCNT_W-1:0]  tcnt_inc;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;

  assign wr_en    = (state == FILL) && in_valid && in_ready;
  assign wcnt_inc = wcnt + CNT_ONE;
  assign rcnt_inc = rcnt + CNT_ONE;
  assign tcnt_inc = tcnt + TCNT_ONE;
  assign wr_addr  = wcnt[ADDR_W-1:0];
  assign rd_addr  = rcnt[ADDR_W-1:0];

  // Tail-biting needs at least M bits so the seed is made of real frame bits.
  assign cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_CFG) &&
                     (!cfg_tailbite || (cfg_len >= M_CFG));

  // History register: bit 0 is the newest accepted bit, bit M-1 the oldest.
  assign lastbits_next[0] = in_bit;
  for (genvar gi = 1; gi < M; gi++) begin : g_shift
    assign lastbits_next[gi] = lastbits[gi-1];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_mem[wr_addr] <= in_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      len_reg        <= '0;
      tailbite_reg   <= 1'b0;
      wcnt           <= '0;
      rcnt           <= '0;
      tcnt           <= '0;
      lastbits       <= '0;
      in_ready       <= 1'b0;
      enc_seed_load  <= 1'b0;
      enc_seed_value <= '0;
      enc_in_valid   <= 1'b0;
      enc_in_bit     <= 1'b0;
      frame_sof      <= 1'b0;
      frame_eof      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      enc_seed_load  <= 1'b0;
      enc_seed_value <= '0;
      enc_in_valid   <= 1'b0;
      enc_in_bit     <= 1'b0;
      frame_sof      <= 1'b0;
      frame_eof      <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_legal) begin
              state        <= FILL;
              len_reg      <= cfg_len[CNT_W-1:0];
              tailbite_reg <= cfg_tailbite;
              wcnt         <= '0;
              rcnt         <= '0;
              tcnt         <= '0;
              lastbits     <= '0;
              in_ready     <= 1'b1;
              busy         <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        FILL: begin
          if (in_valid && in_ready) begin
            wcnt     <= wcnt_inc;
            lastbits <= lastbits_next;
            if (wcnt_inc == len_reg) begin
              // Seed is presented straight from the updated history so the
              // final info bit is already part of it.
              state          <= SEED;
              in_ready       <= 1'b0;
              enc_seed_load  <= 1'b1;
              enc_seed_value <= tailbite_reg ? lastbits_next : '0;
            end
          end
        end

        SEED: begin
          state        <= DATA;
          enc_in_valid <= 1'b1;
          enc_in_bit   <= frame_mem[rd_addr];
          frame_sof    <= 1'b1;
          frame_eof    <= tailbite_reg && (len_reg == CNT_ONE);
          rcnt         <= rcnt_inc;
        end

        DATA: begin
          if (rcnt != len_reg) begin
            enc_in_valid <= 1'b1;
            enc_in_bit   <= frame_mem[rd_addr];
            frame_eof    <= tailbite_reg && (rcnt_inc == len_reg);
            rcnt         <= rcnt_inc;
          end else if (tailbite_reg) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state        <= TAIL;
            enc_in_valid <= 1'b1;
            frame_eof    <= (M_TAIL == TCNT_ONE);
            tcnt         <= TCNT_ONE;
          end
        end

        TAIL: begin
          if (tcnt != M_TAIL) begin
            enc_in_valid <= 1'b1;
            frame_eof    <= (tcnt_inc == M_TAIL);
            tcnt         <= tcnt_inc;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: zero-tail, tail-biting, bursty input,
// illegal configs, maximum length and mid-frame reset.
module tb_conv_frame_sequencer;

  localparam int K       = 4;
  localparam int M       = K - 1;
  localparam int MAX_LEN = 256;
  localparam int LEN_W   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_tailbite = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             in_ready;
  logic             enc_seed_load;
  logic [M-1:0]     enc_seed_value;
  logic             enc_in_valid;
  logic             enc_in_bit;
  logic             frame_sof;
  logic             frame_eof;
  logic             busy;
  logic             done;
  logic             cfg_err;

  conv_frame_sequencer #(
    .K(K), .M(M), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_tailbite(cfg_tailbite),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .enc_seed_load(enc_seed_load), .enc_seed_value(enc_seed_value),
    .enc_in_valid(enc_in_valid), .enc_in_bit(enc_in_bit),
    .frame_sof(frame_sof), .frame_eof(frame_eof),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic stim [0:MAX_LEN+7];

  // Cumulative observation of the encoder-facing side, sampled on the falling edge.
  int           cyc = 0;
  int           seed_cnt = 0;
  int           seed_cyc = 0;
  logic [M-1:0] seed_seen = '0;
  int           last_cyc = 0;
  int           enc_cnt = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           err_cnt = 0;
  int           overlap_cnt = 0;
  int           busy_bad = 0;
  int           stray_cnt = 0;
  logic         q_bit [$];
  logic         q_sof [$];
  logic         q_eof [$];

  always @(negedge clk) begin
    cyc++;
    if (enc_seed_load) begin
      seed_cnt++;
      seed_seen = enc_seed_value;
      seed_cyc  = cyc;
    end
    if (enc_in_valid) begin
      q_bit.push_back(enc_in_bit);
      q_sof.push_back(frame_sof);
      q_eof.push_back(frame_eof);
      last_cyc = cyc;
    end
    if (enc_seed_load || enc_in_valid) enc_cnt++;
    if (enc_seed_load && enc_in_valid) overlap_cnt++;
    if ((frame_sof || frame_eof) && !enc_in_valid) stray_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cfg_err) err_cnt++;
    if ((enc_seed_load || enc_in_valid || done) && !busy) busy_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({in_ready, enc_seed_load, enc_seed_value, enc_in_valid, enc_in_bit,
                frame_sof, frame_eof, busy, done, cfg_err});
  endfunction

  // Starts a frame and feeds len bits; returns just after the edge accepting the last bit.
  task automatic fill_frame(input string tag, input int len, input logic tb,
                            input bit bursty, input bit poke);
    int  idx;
    int  n;
    bit  hs;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_len = LEN_W'(len); cfg_tailbite = tb;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    idx = 0;
    n = 0;
    while (idx < len && n < 4 * len + 20) begin
      in_valid = bursty ? (n % 3 == 0) : 1'b1;
      in_bit   = in_valid ? stim[idx] : ~stim[idx];
      if (poke) begin
        cfg_start = (n == 2);
        cfg_len = '0;
        cfg_tailbite = 1'b0;
      end
      @(negedge clk);
      if (n == 0) begin
        chk({tag, "_fill_busy"}, 32'(busy), 1);
        chk({tag, "_fill_ready"}, 32'(in_ready), 1);
      end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      n++;
    end
    in_valid = 1'b0;
    cfg_start = 1'b0;
    chk({tag, "_accepted"}, idx, len);
  endtask

  task automatic run_frame(input string tag, input int len, input logic tb,
                           input bit bursty, input bit poke);
    int           b_seed, b_enc, b_done, b_err, b_q;
    int           n, got, exp_n, mism_bit, mism_sof, mism_eof;
    logic [M-1:0] exp_seed;
    logic         exp_bit;
    b_seed = seed_cnt; b_enc = enc_cnt; b_done = done_cnt; b_err = err_cnt;
    b_q = q_bit.size();
    fill_frame(tag, len, tb, bursty, poke);
    n = 0;
    while (done_cnt == b_done && n < MAX_LEN + 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 0);

    exp_n = len + (tb ? 0 : M);
    for (int j = 0; j < M; j++) exp_seed[j] = tb ? stim[len-1-j] : 1'b0;
    got = q_bit.size() - b_q;
    mism_bit = 0; mism_sof = 0; mism_eof = 0;
    for (int i = 0; i < got; i++) begin
      exp_bit = (i < len) ? stim[i] : 1'b0;
      if (q_bit[b_q+i] !== exp_bit) mism_bit++;
      if (q_sof[b_q+i] !== (i == 0)) mism_sof++;
      if (q_eof[b_q+i] !== (i == exp_n - 1)) mism_eof++;
    end
    chk({tag, "_seed_count"}, seed_cnt - b_seed, 1);
    chk({tag, "_seed_value"}, 32'(seed_seen), 32'(exp_seed));
    chk({tag, "_bit_count"}, got, exp_n);
    chk({tag, "_bit_mismatch"}, mism_bit, 0);
    chk({tag, "_sof_mismatch"}, mism_sof, 0);
    chk({tag, "_eof_mismatch"}, mism_eof, 0);
    chk({tag, "_enc_cycles"}, enc_cnt - b_enc, exp_n + 1);
    chk({tag, "_enc_span"}, last_cyc - seed_cyc + 1, exp_n + 1);
    chk({tag, "_done_count"}, done_cnt - b_done, 1);
    chk({tag, "_done_cycle"}, done_cyc, last_cyc + 1);
    chk({tag, "_cfg_err"}, err_cnt - b_err, 0);
    $display("frame %s len=%0d tailbite=%0d bits=%0d seed=%b", tag, len, tb, got, seed_seen);
  endtask

  task automatic bad_cfg(input string tag, input int len, input logic tb);
    int b_err;
    b_err = err_cnt;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_len = LEN_W'(len); cfg_tailbite = tb;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    chk({tag, "_err_pulse"}, 32'(cfg_err), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_err_clear"}, 32'(cfg_err), 0);
    chk({tag, "_busy2"}, 32'(busy), 0);
    chk({tag, "_err_count"}, err_cnt - b_err, 1);
    $display("config %s len=%0d tailbite=%0d cfg_err=%0d", tag, len, tb, err_cnt - b_err);
  endtask

  initial begin
    int b_done;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    stim[0] = 1'b1; stim[1] = 1'b0; stim[2] = 1'b1; stim[3] = 1'b1; stim[4] = 1'b0;
    run_frame("zt5", 5, 1'b0, 1'b0, 1'b0);
    run_frame("tb5", 5, 1'b1, 1'b0, 1'b0);
    run_frame("tb5_bursty", 5, 1'b1, 1'b1, 1'b0);
    run_frame("zt5_bursty", 5, 1'b0, 1'b1, 1'b0);

    bad_cfg("len0", 0, 1'b0);
    bad_cfg("len257", MAX_LEN + 1, 1'b0);
    bad_cfg("tb_len2", 2, 1'b1);

    for (int i = 0; i < MAX_LEN; i++) stim[i] = (i % 2 == 0);
    run_frame("zt256", MAX_LEN, 1'b0, 1'b0, 1'b0);

    // Abort while the third data bit is on the encoder interface.
    stim[0] = 1'b1; stim[1] = 1'b0; stim[2] = 1'b1; stim[3] = 1'b1; stim[4] = 1'b0;
    b_done = done_cnt;
    fill_frame("abort", 5, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_valid_bit2", 32'(enc_in_valid), 1);
    chk("abort_value_bit2", 32'(enc_in_bit), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", out_vec(), 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", done_cnt - b_done, 0);
    $display("frame abort len=5 reset during data bit 2");

    stim[0] = 1'b0; stim[1] = 1'b1; stim[2] = 1'b1; stim[3] = 1'b0;
    stim[4] = 1'b1; stim[5] = 1'b1;
    run_frame("after_abort_poke", 6, 1'b1, 1'b0, 1'b1);

    chk("seed_valid_overlap", overlap_cnt, 0);
    chk("busy_low_activity", busy_bad, 0);
    chk("stray_sof_eof", stray_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
